// File: rtl/bus_pkg.sv
// Shared definitions for the bus master request controller.
package bus_pkg;

  localparam int unsigned BUS_ADDR_W = 8;
  localparam int unsigned BUS_DATA_W = 32;
  localparam int unsigned BUS_LEN_W  = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StReq    = 2'd1,
    StXfer   = 2'd2,
    StRdTail = 2'd3
  } bus_state_e;

endpackage

// File: rtl/bus_beat_cnt.sv
// Beat index for one burst, last-beat flag and wrapped beat address.
module bus_beat_cnt
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W = BUS_ADDR_W,
  parameter int unsigned LEN_W  = BUS_LEN_W
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_clr,
  input  logic              i_inc,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_last,
  output logic [ADDR_W-1:0] o_addr
);

  logic [LEN_W-1:0] r_idx;

  // Beat index: cleared on command accept, advanced once per issued beat.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_idx <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_inc) begin
      r_idx <= r_idx + LEN_W'(1);
    end
  end

  assign o_last = (r_idx == i_len);
  // Address wraps naturally at the bus address width.
  assign o_addr = i_base + ADDR_W'(r_idx);

endmodule

// File: rtl/bus_master_ctrl.sv
// Master-side bus request controller: takes a burst command, requests the bus,
// issues one beat per granted cycle and returns read data to the engine.
module bus_master_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W = BUS_ADDR_W,
  parameter int unsigned DATA_W = BUS_DATA_W,
  parameter int unsigned LEN_W  = BUS_LEN_W
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_wr,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_pop,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_done,
  output logic              o_m_req,
  input  logic              i_m_grt,
  output logic              o_m_wr,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [DATA_W-1:0] o_m_dout,
  input  logic [DATA_W-1:0] i_m_din
);

  bus_state_e        r_state;
  logic              r_wr;
  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]  r_len;
  logic              r_cmd_ready;
  logic              r_m_req;
  logic              r_rd_valid;
  logic              r_done;

  logic              w_accept;
  logic              w_in_xfer;
  logic              w_beat;
  logic              w_last;
  logic              w_last_beat;
  logic [ADDR_W-1:0] w_addr;

  assign w_accept    = (r_state == StIdle) && i_cmd_valid;
  assign w_in_xfer   = (r_state == StXfer);
  // A beat goes out on every granted XFER cycle; ungranted cycles stall.
  assign w_beat      = w_in_xfer && i_m_grt;
  assign w_last_beat = w_beat && w_last;

  bus_beat_cnt #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_beat_cnt (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clr     (w_accept),
    .i_inc     (w_beat),
    .i_base    (r_base),
    .i_len     (r_len),
    .o_last    (w_last),
    .o_addr    (w_addr)
  );

  // Burst sequencing plus the registered handshake/status outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= StIdle;
      r_wr        <= 1'b0;
      r_base      <= '0;
      r_len       <= '0;
      r_cmd_ready <= 1'b1;
      r_m_req     <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // Slave answers a read one cycle after the address; done lands the
      // cycle after the final beat for both directions.
      r_rd_valid <= w_beat && !r_wr;
      r_done     <= w_last_beat;
      unique case (r_state)
        StIdle: begin
          if (i_cmd_valid) begin
            r_wr        <= i_cmd_wr;
            r_base      <= i_cmd_addr;
            r_len       <= i_cmd_len;
            r_cmd_ready <= 1'b0;
            r_m_req     <= 1'b1;
            r_state     <= StReq;
          end
        end
        StReq: begin
          if (i_m_grt) r_state <= StXfer;
        end
        StXfer: begin
          if (w_last_beat) begin
            r_m_req <= 1'b0;
            if (r_wr) begin
              r_cmd_ready <= 1'b1;
              r_state     <= StIdle;
            end else begin
              r_state <= StRdTail;
            end
          end
        end
        StRdTail: begin
          r_cmd_ready <= 1'b1;
          r_state     <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_m_req     = r_m_req;
  assign o_done      = r_done;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_data   = r_rd_valid ? i_m_din : '0;
  assign o_m_wr      = w_beat && r_wr;
  assign o_wr_pop    = w_beat && r_wr;
  assign o_m_addr    = w_in_xfer ? w_addr : '0;
  assign o_m_dout    = w_in_xfer ? i_wr_data : '0;

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Self-checking bench for bus_master_ctrl.
module tb_bus_master_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [7:0]  cmd_addr;
  logic [3:0]  cmd_len;
  logic [31:0] wr_data, rd_data, m_dout, m_din;
  logic        wr_pop, rd_valid, done, m_req, m_grt, m_wr;
  logic [7:0]  m_addr;

  int total = 0;
  int bad   = 0;

  // Engine write queue model and slave read model.
  logic [15:0] wr_seq  = 16'h0;
  logic [7:0]  slv_addr = 8'h0;
  assign wr_data = {16'hDA7A, wr_seq};
  assign m_din   = {24'h0, slv_addr ^ 8'hA5};
  always @(posedge clk) begin
    if (wr_pop) wr_seq <= wr_seq + 16'd1;
    slv_addr <= m_addr;
  end

  initial forever #5 clk = ~clk;

  bus_master_ctrl #(.ADDR_W(8), .DATA_W(32), .LEN_W(4)) dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_wr    (cmd_wr),
    .i_cmd_addr  (cmd_addr),
    .i_cmd_len   (cmd_len),
    .i_wr_data   (wr_data),
    .o_wr_pop    (wr_pop),
    .o_rd_data   (rd_data),
    .o_rd_valid  (rd_valid),
    .o_done      (done),
    .o_m_req     (m_req),
    .i_m_grt     (m_grt),
    .o_m_wr      (m_wr),
    .o_m_addr    (m_addr),
    .o_m_dout    (m_dout),
    .i_m_din     (m_din)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One burst, checked cycle by cycle against the burst rules:
  // REQ cycles until grant, then beats on granted cycles at base+k, done the
  // cycle after the last beat, read data one cycle after each read beat.
  task automatic run_burst(input bit wr, input logic [7:0] base, input logic [3:0] len,
                           input int gdelay, input int stall_at, input int stall_n,
                           input int gpct, input bit noise,
                           output int n_beats, output logic [7:0] last_addr,
                           output logic [31:0] last_rd);
    int ph, req_cyc, stalls, n_rdv;
    bit fin, prev_beat, cur_beat;
    logic [7:0]  a8;
    logic [15:0] seq0;
    n_beats = 0; last_addr = 8'h0; last_rd = 32'h0;
    ph = 0; req_cyc = 0; stalls = 0; n_rdv = 0; fin = 0; prev_beat = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_wr = wr; cmd_addr = base; cmd_len = len; m_grt = 0;
    #2;
    chk("idle_ready", cmd_ready, 1);
    chk("idle_req", m_req, 0);
    @(negedge clk);
    seq0 = wr_seq;
    for (int t = 0; t < 300 && !fin; t++) begin
      if (ph == 0) m_grt = (req_cyc >= gdelay);
      else if (ph == 1 && n_beats == stall_at && stalls < stall_n) begin
        m_grt = 0;
        stalls++;
      end else if (ph == 1) m_grt = ($urandom_range(99) < gpct);
      else m_grt = 1'($urandom_range(1));
      if (noise && ph != 2) begin
        cmd_valid = 1'($urandom_range(1));
        cmd_addr  = 8'($urandom);
        cmd_len   = 4'($urandom);
        cmd_wr    = 1'($urandom_range(1));
      end else begin
        cmd_valid = 0;
      end
      #2;
      cur_beat = (ph == 1) && m_grt;
      chk("rd_valid", rd_valid, !wr && prev_beat);
      if (rd_valid) begin
        a8 = base + 8'(n_rdv);
        chk("rd_data", rd_data, {24'h0, a8 ^ 8'hA5});
        n_rdv++;
        last_rd = rd_data;
      end
      chk("done", done, ph == 2);
      chk("cmd_ready", cmd_ready, ph == 2 && wr);
      chk("m_req", m_req, ph != 2);
      chk("m_wr", m_wr, cur_beat && wr);
      chk("wr_pop", wr_pop, cur_beat && wr);
      if (ph == 1) begin
        a8 = base + 8'(n_beats);
        chk("m_addr", m_addr, a8);
        if (wr) chk("m_dout", m_dout, {16'hDA7A, seq0 + 16'(n_beats)});
      end
      prev_beat = cur_beat;
      if (ph == 0) begin
        if (m_grt) ph = 1;
        else req_cyc++;
      end else if (ph == 1) begin
        if (m_grt) begin
          last_addr = m_addr;
          n_beats++;
          if (n_beats == int'(len) + 1) ph = 2;
        end
      end else begin
        fin = 1;
      end
      if (!fin) @(negedge clk);
    end
    chk("burst_end", fin, 1);
    cmd_valid = 0;
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] base;
    logic [3:0] len;
    int         gdelay, stall_at, stall_n;
    int         exp_beats;
    logic [7:0] exp_last_addr;
    logic [7:0] exp_last_rd;
  } burst_t;

  typedef struct {
    bit v, w;
    logic [7:0] a;
    logic [3:0] l;
    bit g;
    bit rdy, req, mwr, pop, rdv, dn;
    int addr, rdat;   // -1 = not checked
  } vec_t;

  burst_t bursts[5];
  vec_t   vecs[11];

  initial begin
    int nb;
    logic [7:0]  la;
    logic [31:0] lr;
    reset_n = 0; cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_len = 0; m_grt = 0;

    bursts[0] = '{1, 8'h10, 4'd3,  2, 0, 0, 4,  8'h13, 8'h00};
    bursts[1] = '{0, 8'hFE, 4'd2,  0, 0, 0, 3,  8'h00, 8'hA5};
    bursts[2] = '{1, 8'h50, 4'd3,  0, 1, 3, 4,  8'h53, 8'h00};
    bursts[3] = '{0, 8'hF8, 4'd15, 1, 7, 2, 16, 8'h07, 8'hA2};
    bursts[4] = '{1, 8'hFF, 4'd0,  0, 0, 1, 1,  8'hFF, 8'h00};

    // Busy-time command ignored, accept in the done cycle, then a 1-beat read.
    vecs[0]  = '{1, 1, 8'h20, 4'd1, 1, 1, 0, 0, 0, 0, 0, -1, -1};
    vecs[1]  = '{1, 1, 8'h80, 4'd1, 1, 0, 1, 0, 0, 0, 0, -1, -1};
    vecs[2]  = '{1, 1, 8'h80, 4'd1, 1, 0, 1, 1, 1, 0, 0, 32'h20, -1};
    vecs[3]  = '{1, 1, 8'h80, 4'd1, 1, 0, 1, 1, 1, 0, 0, 32'h21, -1};
    vecs[4]  = '{1, 0, 8'h80, 4'd0, 0, 1, 0, 0, 0, 0, 1, -1, -1};
    vecs[5]  = '{0, 0, 8'h00, 4'd0, 0, 0, 1, 0, 0, 0, 0, -1, -1};
    vecs[6]  = '{0, 0, 8'h00, 4'd0, 1, 0, 1, 0, 0, 0, 0, -1, -1};
    vecs[7]  = '{0, 0, 8'h00, 4'd0, 1, 0, 1, 0, 0, 0, 0, 32'h80, -1};
    vecs[8]  = '{0, 0, 8'h00, 4'd0, 1, 0, 0, 0, 0, 1, 1, -1, 32'h25};
    vecs[9]  = '{0, 0, 8'h00, 4'd0, 1, 1, 0, 0, 0, 0, 0, -1, -1};
    vecs[10] = '{0, 0, 8'h00, 4'd0, 1, 1, 0, 0, 0, 0, 0, -1, -1};

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_req", m_req, 0);
    chk("rst_wr", m_wr, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_dout", m_dout, 0);
    chk("rst_pop", wr_pop, 0);
    chk("rst_rdv", rd_valid, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_done", done, 0);
    reset_n = 1;

    // Directed bursts.
    foreach (bursts[i]) begin
      run_burst(bursts[i].wr, bursts[i].base, bursts[i].len, bursts[i].gdelay,
                bursts[i].stall_at, bursts[i].stall_n, 100, 0, nb, la, lr);
      chk("tbl_beats", nb, bursts[i].exp_beats);
      chk("tbl_last_addr", la, bursts[i].exp_last_addr);
      if (!bursts[i].wr) chk("tbl_last_rd", lr, {24'h0, bursts[i].exp_last_rd});
    end

    // Cycle vectors.
    foreach (vecs[i]) begin
      @(negedge clk);
      cmd_valid = vecs[i].v; cmd_wr = vecs[i].w; cmd_addr = vecs[i].a;
      cmd_len = vecs[i].l; m_grt = vecs[i].g;
      #2;
      chk("vec_ready", cmd_ready, vecs[i].rdy);
      chk("vec_req", m_req, vecs[i].req);
      chk("vec_wr", m_wr, vecs[i].mwr);
      chk("vec_pop", wr_pop, vecs[i].pop);
      chk("vec_rdv", rd_valid, vecs[i].rdv);
      chk("vec_done", done, vecs[i].dn);
      if (vecs[i].addr >= 0) chk("vec_addr", m_addr, vecs[i].addr);
      if (vecs[i].rdat >= 0) chk("vec_rdata", rd_data, vecs[i].rdat);
    end

    // Reset during the third beat of a write aborts it without done.
    @(negedge clk); cmd_valid = 1; cmd_wr = 1; cmd_addr = 8'h30; cmd_len = 4'd3; m_grt = 1;
    @(negedge clk); cmd_valid = 0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); reset_n = 0;
    @(negedge clk); reset_n = 1;
    #2;
    chk("abort_req", m_req, 0);
    chk("abort_wr", m_wr, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_addr", m_addr, 0);
    repeat (4) begin
      @(negedge clk);
      #2;
      chk("abort_pop", wr_pop, 0);
      chk("abort_idle_req", m_req, 0);
      chk("abort_idle_done", done, 0);
    end

    // Randomized bursts with grant jitter and busy-time command noise.
    for (int k = 0; k < 40; k++) begin
      logic [3:0] rl;
      rl = 4'($urandom);
      run_burst(1'($urandom_range(1)), 8'($urandom), rl, $urandom_range(3),
                $urandom_range(int'(rl)), $urandom_range(3), $urandom_range(100, 40), 1,
                nb, la, lr);
      chk("rnd_beats", nb, int'(rl) + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
